op_sequencer: RTL and testbench
===============================

Name: op_sequencer

Overview:
Instruction sequencer for the operation block (ALU + accumulator). It fetches byte-wide instructions and operands from program memory over a req/ack handshake and decodes them. It drives the ALU opcode, the B operand and the accumulator clock-enable, and latches the carry flag. It also presents accumulator results on an output port with valid/ready handshake. Sits between program memory and operation_block as the processor's control unit.

Parameters:
ADDR_W, 8, program counter / memory address width
RESET_PC, 0, PC value loaded on reset and on restart

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin execution from RESET_PC (honoured in IDLE and HALT only)
mem_addr  output  ADDR_W  program memory address
mem_req  output  1  memory read request, held until mem_ack
mem_ack  input  1  memory read done; mem_rdata valid in same cycle
mem_rdata  input  8  memory read data
alu_op  output  3  to operation_code; always IR[2:0]
b_operand  output  8  to in_b; always operand register
aku_ce  output  1  to aku_enable; one-cycle pulse in EXEC of ALU instruction
acc_in  input  8  from out_result (accumulator value)
carry_in  input  1  from Carry_flag (combinational ALU carry)
carry_flag  output  1  latched carry
out_data  output  8  output port data
out_valid  output  1  output port valid
out_ready  input  1  output port ready
halted  output  1  1 in HALT state
illegal  output  1  sticky illegal-opcode flag
pc  output  ADDR_W  current program counter

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc=RESET_PC; IR=0; operand=0; carry_flag=0; out_data=0; out_valid=0; mem_req=0; aku_ce=0; halted=0; illegal=0. Takes effect immediately, also mid-fetch: mem_req drops in the same cycle.
- Instruction byte: IR[7:4] major opcode, IR[2:0] ALU op. 0x0 NOP; 0x1 ALU (+operand byte); 0x2 JMP (+target byte); 0x3 JC (+target byte); 0x4 OUT; 0xF HALT; all others illegal.
- States: IDLE, FETCH, DECODE, OPFETCH, EXEC, OUTW, HALT.
- IDLE: waits for start=1, then goes to FETCH.
- FETCH: mem_req=1, mem_addr=pc. On a mem_ack edge: IR<=mem_rdata, pc<=pc+1, go to DECODE.
- DECODE (1 cycle), next state by opcode: NOP -> FETCH; ALU/JMP/JC -> OPFETCH; OUT -> OUTW; HALT -> HALT; illegal -> illegal<=1, HALT.
- OPFETCH: mem_req=1, mem_addr=pc. On mem_ack: operand<=mem_rdata, pc<=pc+1, go to EXEC.
- EXEC (1 cycle), then FETCH:
  - ALU: aku_ce=1 and carry_flag<=carry_in on the closing edge, so the accumulator and carry update together.
  - JMP: pc<=operand.
  - JC: pc<=operand if carry_flag=1, else pc unchanged.
- OUTW: out_valid=1, out_data=acc_in (accumulator is stable because aku_ce=0). In the cycle where out_valid and out_ready are both 1, the transfer completes: out_valid<=0, go to FETCH. out_ready while out_valid=0 is ignored.
- HALT: halted=1, no memory requests. start=1 -> pc<=RESET_PC, halted<=0, illegal<=0, go to FETCH. Otherwise HALT is held.
- mem_req stays high until mem_ack; mem_addr is stable while mem_req=1; mem_ack with mem_req=0 is ignored.
- aku_ce=0 in every state except EXEC of an ALU instruction.
- Latency with zero-wait memory (ack in the request cycle): NOP 2 cycles, ALU/JMP/JC 4 cycles, OUT 3 cycles minimum. Each memory wait cycle adds 1.
- PC wraps modulo 2^ADDR_W (0xFF+1 -> 0x00), both on fetch increment and operand increment.
- start outside IDLE/HALT is ignored.

Test Plan:
- Reset/IDLE: assert rst_n=0 mid-FETCH with mem_req=1 -> mem_req=0, pc=0x00, aku_ce=0 immediately. Then start pulse -> mem_req=1, mem_addr=0x00.
- ALU: memory {0x00:0x16, 0x01:0x0A}, zero-wait ack -> alu_op=3'd6, b_operand=0x0A, aku_ce high exactly 1 cycle at cycle 4, carry_flag=carry_in sampled on that edge, pc=0x02.
- Wait states plus NOP: ack delayed 3 cycles on each access for {0x00:0x00, 0x01:0xF0} -> mem_addr held during the waits, NOP takes 5 cycles, then HALT with halted=1 and pc=0x02.
- JMP/JC: program {0x00:0x20, 0x01:0x10, 0x10:0x30, 0x11:0x40} with carry_flag=0 -> pc=0x10 after JMP, JC not taken so pc=0x12. Repeat with carry_flag=1 -> pc=0x40.
- OUT backpressure: OUT with acc_in=0x5A, out_ready low for 4 cycles -> out_valid=1 and out_data=0x5A held. out_ready=1 -> one transfer, out_valid drops, next FETCH.
- Illegal/wrap: opcode 0x70 at 0xFF -> illegal=1, halted=1, pc=0x00 (wrap). start -> illegal=0, fetch at RESET_PC.

Source files
------------

// File: rtl/op_sequencer.sv
// op_sequencer: byte-code fetch/decode/execute control unit for the
// ALU + accumulator operation block.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start              begin execution (honoured in IDLE / HALT)
//   mem_addr/req/ack   program memory read handshake, mem_rdata data
//   alu_op, b_operand  ALU opcode (IR[2:0]) and B operand
//   aku_ce             accumulator enable, 1-cycle pulse in ALU EXEC
//   acc_in, carry_in   accumulator value and ALU carry
//   carry_flag         latched carry
//   out_data/valid/rdy output port with valid/ready handshake
//   halted, illegal    status (illegal is sticky until restart)
//   pc                 program counter
module op_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [2:0]        alu_op,
    output logic [7:0]        b_operand,
    output logic              aku_ce,
    input  logic [7:0]        acc_in,
    input  logic              carry_in,
    output logic              carry_flag,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPFETCH,
        S_EXEC,
        S_OUTW,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_ir;
    logic [7:0]        r_operand;
    logic              r_mem_req;
    logic              r_aku_ce;
    logic              r_carry;
    logic [7:0]        r_out_data;
    logic              r_out_valid;
    logic              r_halted;
    logic              r_illegal;

    logic              w_nop;
    logic              w_alu;
    logic              w_jmp;
    logic              w_jc;
    logic              w_out;
    logic              w_hlt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_target;

    assign w_nop    = (r_ir[7:4] == 4'h0);
    assign w_alu    = (r_ir[7:4] == 4'h1);
    assign w_jmp    = (r_ir[7:4] == 4'h2);
    assign w_jc     = (r_ir[7:4] == 4'h3);
    assign w_out    = (r_ir[7:4] == 4'h4);
    assign w_hlt    = (r_ir[7:4] == 4'hF);
    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_target = ADDR_W'(r_operand);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_ir        <= 8'h00;
            r_operand   <= 8'h00;
            r_mem_req   <= 1'b0;
            r_aku_ce    <= 1'b0;
            r_carry     <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_aku_ce <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir      <= mem_rdata;
                        r_pc      <= w_pc_inc;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    unique case (1'b1)
                        w_nop: begin
                            r_state   <= S_FETCH;
                            r_mem_req <= 1'b1;
                        end
                        w_alu, w_jmp, w_jc: begin
                            r_state   <= S_OPFETCH;
                            r_mem_req <= 1'b1;
                        end
                        w_out: begin
                            // accumulator cannot change in OUTW (aku_ce=0)
                            r_state     <= S_OUTW;
                            r_out_valid <= 1'b1;
                            r_out_data  <= acc_in;
                        end
                        w_hlt: begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                        default: begin
                            r_state   <= S_HALT;
                            r_halted  <= 1'b1;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_OPFETCH: begin
                    if (mem_ack) begin
                        r_operand <= mem_rdata;
                        r_pc      <= w_pc_inc;
                        r_mem_req <= 1'b0;
                        r_aku_ce  <= w_alu;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // carry latches on the same edge the accumulator loads
                    if (w_alu) begin
                        r_carry <= carry_in;
                    end
                    if (w_jmp || (w_jc && r_carry)) begin
                        r_pc <= w_target;
                    end
                    r_state   <= S_FETCH;
                    r_mem_req <= 1'b1;
                end
                S_OUTW: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_FETCH;
                        r_mem_req   <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        r_pc      <= RESET_PC;
                        r_halted  <= 1'b0;
                        r_illegal <= 1'b0;
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr   = r_pc;
    assign mem_req    = r_mem_req;
    assign alu_op     = r_ir[2:0];
    assign b_operand  = r_operand;
    assign aku_ce     = r_aku_ce;
    assign carry_flag = r_carry;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign halted     = r_halted;
    assign illegal    = r_illegal;
    assign pc         = r_pc;

endmodule

// File: tb/tb_op_sequencer.sv
// Testbench for op_sequencer: memory model with programmable wait
// states, scoreboards for ALU strobes and output-port transfers.
module tb_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [2:0] alu_op;
    logic [7:0] b_operand;
    logic       aku_ce;
    logic [7:0] acc_in;
    logic       carry_in;
    logic       carry_flag;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       halted;
    logic       illegal;
    logic [7:0] pc;

    logic [7:0]  mem [256];
    int          waits;
    int          wcnt;
    int          n_chk;
    int          n_err;
    int          n_xfer;
    logic [10:0] alu_q [$];
    logic [7:0]  out_q [$];

    op_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .alu_op     (alu_op),
        .b_operand  (b_operand),
        .aku_ce     (aku_ce),
        .acc_in     (acc_in),
        .carry_in   (carry_in),
        .carry_flag (carry_flag),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .halted     (halted),
        .illegal    (illegal),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack   = mem_req && (wcnt >= waits);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && aku_ce) begin
            if (alu_q.size() == 0) begin
                chk("alu_q_empty", 1, 0);
            end else begin
                logic [10:0] e;
                e = alu_q.pop_front();
                chk("sb_alu_op", alu_op, e[10:8]);
                chk("sb_b_operand", b_operand, e[7:0]);
            end
        end
        if (rst_n && out_valid && out_ready) begin
            n_xfer++;
            if (out_q.size() == 0) begin
                chk("out_q_empty", 1, 0);
            end else begin
                chk("sb_out_data", out_data, out_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic mem_fill();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic wait_halt(input string tag, input int max);
        int k;
        k = 0;
        while (!halted && k < max) begin
            tick();
            k++;
        end
        chk(tag, halted, 1);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        n_xfer    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        waits     = 0;
        acc_in    = 8'h00;
        carry_in  = 1'b0;
        out_ready = 1'b0;
        mem_fill();

        // reset state and reset mid-fetch
        do_reset();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_carry", carry_flag, 0);
        waits = 100;
        pulse_start();
        tick();
        chk("fetch_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_pc", pc, 8'h00);
        chk("async_aku_ce", aku_ce, 0);
        tick();
        rst_n = 1'b1;
        waits = 0;
        tick();
        pulse_start();
        chk("start_req", mem_req, 1);
        chk("start_addr", mem_addr, 8'h00);
        wait_halt("rst_halt", 20);

        // ALU, zero-wait
        do_reset();
        mem_fill();
        mem[0] = 8'h16;
        mem[1] = 8'h0A;
        carry_in = 1'b1;
        alu_q.push_back({3'd6, 8'h0A});
        pulse_start();
        chk("alu_ce_c1", aku_ce, 0);
        tick();
        chk("alu_ce_c2", aku_ce, 0);
        tick();
        chk("alu_ce_c3", aku_ce, 0);
        tick();
        chk("alu_ce_c4", aku_ce, 1);
        chk("alu_op", alu_op, 3'd6);
        chk("alu_b", b_operand, 8'h0A);
        chk("alu_pc", pc, 8'h02);
        tick();
        carry_in = 1'b0;
        chk("alu_ce_c5", aku_ce, 0);
        chk("alu_carry", carry_flag, 1);
        wait_halt("alu_halt", 20);
        chk("alu_carry_hold", carry_flag, 1);

        // wait states + NOP
        do_reset();
        mem_fill();
        mem[0] = 8'h00;
        mem[1] = 8'hF0;
        waits = 3;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            chk("ws_req", mem_req, 1);
            chk("ws_addr", mem_addr, 8'h00);
            tick();
        end
        chk("ws_ack_addr", mem_addr, 8'h00);
        tick();
        chk("ws_decode_req", mem_req, 0);
        chk("ws_decode_pc", pc, 8'h01);
        tick();
        chk("ws_next_req", mem_req, 1);
        chk("ws_next_addr", mem_addr, 8'h01);
        wait_halt("ws_halt", 20);
        chk("ws_halt_pc", pc, 8'h02);
        waits = 0;

        // JMP then JC not taken
        do_reset();
        mem_fill();
        mem[8'h00] = 8'h20;
        mem[8'h01] = 8'h10;
        mem[8'h10] = 8'h30;
        mem[8'h11] = 8'h40;
        pulse_start();
        ticks(4);
        chk("jmp_pc", pc, 8'h10);
        ticks(4);
        chk("jc_nt_pc", pc, 8'h12);
        wait_halt("jc_nt_halt", 20);
        chk("jc_nt_hpc", pc, 8'h13);

        // ALU sets carry, then JMP, JC taken
        do_reset();
        mem_fill();
        mem[8'h00] = 8'h10;
        mem[8'h01] = 8'h00;
        mem[8'h02] = 8'h20;
        mem[8'h03] = 8'h10;
        mem[8'h10] = 8'h30;
        mem[8'h11] = 8'h40;
        carry_in = 1'b1;
        alu_q.push_back({3'd0, 8'h00});
        pulse_start();
        ticks(4);
        carry_in = 1'b0;
        chk("jc_carry", carry_flag, 1);
        ticks(4);
        chk("jc_jmp_pc", pc, 8'h10);
        ticks(4);
        chk("jc_t_pc", pc, 8'h40);

        // OUT with backpressure
        do_reset();
        mem_fill();
        mem[0] = 8'h40;
        acc_in = 8'h5A;
        out_q.push_back(8'h5A);
        n_xfer = 0;
        pulse_start();
        ticks(2);
        for (int i = 0; i < 4; i++) begin
            chk("out_valid_hold", out_valid, 1);
            chk("out_data_hold", out_data, 8'h5A);
            chk("out_no_req", mem_req, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("out_next_req", mem_req, 1);
        chk("out_next_addr", mem_addr, 8'h01);
        wait_halt("out_halt", 20);
        chk("out_xfers", n_xfer, 1);

        // illegal opcode at 0xFF, PC wrap, restart
        do_reset();
        mem_fill();
        mem[8'h00] = 8'h20;
        mem[8'h01] = 8'hFF;
        mem[8'hFF] = 8'h70;
        pulse_start();
        ticks(4);
        chk("ill_addr", mem_addr, 8'hFF);
        ticks(2);
        chk("ill_flag", illegal, 1);
        chk("ill_halted", halted, 1);
        chk("ill_pc", pc, 8'h00);
        ticks(3);
        chk("ill_hold_req", mem_req, 0);
        chk("ill_sticky", illegal, 1);
        pulse_start();
        chk("ill_clr", illegal, 0);
        chk("ill_run", halted, 0);
        chk("ill_req", mem_req, 1);
        chk("ill_refetch", mem_addr, 8'h00);

        chk("alu_q_drained", alu_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 1 exp 0");
        $fatal(1);
    end

endmodule
